// File: rtl/dpc_bp_table_arbiter.sv
// Arbitrates the single-port bad-pixel table RAM between the corrector (cor),
// the detector (det) and the AXI-side path (cfg). Read data is returned with a tag.
module dpc_bp_table_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cor_req,
  input  logic [ADDR_WIDTH-1:0] cor_addr,
  output logic                  cor_gnt,
  output logic                  cor_rvalid,
  output logic [DATA_WIDTH-1:0] cor_rdata,
  input  logic                  det_req,
  input  logic [ADDR_WIDTH-1:0] det_addr,
  input  logic [DATA_WIDTH-1:0] det_wdata,
  output logic                  det_gnt,
  input  logic                  cfg_req,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_gnt,
  output logic                  cfg_rvalid,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [3:0]            cfg_starve_cnt
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_COR  = 2'd1,
    TAG_CFG  = 2'd2
  } tag_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  tag_e                  tag_q, tag_d;
  logic [3:0]            starve_q, starve_d;
  logic [DATA_WIDTH-1:0] cor_rdata_q, cfg_rdata_q;

  // cor always wins; a starved cfg then beats det, otherwise det beats cfg
  always_comb begin
    cor_gnt = 1'b0;
    det_gnt = 1'b0;
    cfg_gnt = 1'b0;
    if (!rst) begin
      if (cor_req)                              cor_gnt = 1'b1;
      else if (cfg_req && (starve_q == LIMIT))  cfg_gnt = 1'b1;
      else if (det_req)                         det_gnt = 1'b1;
      else if (cfg_req)                         cfg_gnt = 1'b1;
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cor_gnt) begin
      ram_en   = 1'b1;
      ram_addr = cor_addr;
    end else if (det_gnt) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = det_addr;
      ram_wdata = det_wdata;
    end else if (cfg_gnt) begin
      ram_en    = 1'b1;
      ram_we    = cfg_we;
      ram_addr  = cfg_addr;
      ram_wdata = cfg_we ? cfg_wdata : '0;
    end
  end

  always_comb begin
    starve_d = 4'd0;
    if (cfg_req && !cfg_gnt)
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
    tag_d = TAG_NONE;
    if (cor_gnt)                 tag_d = TAG_COR;
    else if (cfg_gnt && !cfg_we) tag_d = TAG_CFG;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= TAG_NONE;
      starve_q    <= 4'd0;
      cor_rdata_q <= '0;
      cfg_rdata_q <= '0;
    end else begin
      tag_q    <= tag_d;
      starve_q <= starve_d;
      if (tag_q == TAG_COR) cor_rdata_q <= ram_rdata;
      if (tag_q == TAG_CFG) cfg_rdata_q <= ram_rdata;
    end
  end

  // RAM data arrives the cycle after the grant, so the return path is a bypass
  // onto the held copy; reset forces every output to its idle value at once.
  assign cor_rvalid     = !rst && (tag_q == TAG_COR);
  assign cfg_rvalid     = !rst && (tag_q == TAG_CFG);
  assign cor_rdata      = rst ? '0 : (cor_rvalid ? ram_rdata : cor_rdata_q);
  assign cfg_rdata      = rst ? '0 : (cfg_rvalid ? ram_rdata : cfg_rdata_q);
  assign cfg_starve_cnt = rst ? 4'd0 : starve_q;

endmodule

// File: tb/tb_dpc_bp_table_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural arbitration/table model; the RAM itself is an environment model.
module tb_dpc_bp_table_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cor_req, det_req, cfg_req, cfg_we;
  logic [AW-1:0] cor_addr, det_addr, cfg_addr;
  logic [DW-1:0] det_wdata, cfg_wdata;
  logic          cor_gnt, det_gnt, cfg_gnt, cor_rvalid, cfg_rvalid;
  logic [DW-1:0] cor_rdata, cfg_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [3:0]    cfg_starve_cnt;

  always #5 clk = ~clk;

  dpc_bp_table_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .cor_req(cor_req), .cor_addr(cor_addr), .cor_gnt(cor_gnt),
    .cor_rvalid(cor_rvalid), .cor_rdata(cor_rdata),
    .det_req(det_req), .det_addr(det_addr), .det_wdata(det_wdata), .det_gnt(det_gnt),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_gnt(cfg_gnt), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .cfg_starve_cnt(cfg_starve_cnt)
  );

  function automatic logic [DW-1:0] mem_init(input int i);
    if (i == 5) return 32'h0003_2040;
    return (32'h0001_0000 * i) ^ 32'h0000_0AA0 ^ i;
  endfunction

  // environment RAM: synchronous single port, registered read
  logic [DW-1:0] ram_env [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_env[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_env[ram_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int            m_starve = 0;
  int            m_pend = 0;        // 0 none, 1 cor, 2 cfg
  logic [DW-1:0] m_pend_data = '0;
  logic [DW-1:0] m_last_cor = '0, m_last_cfg = '0;
  logic [DW-1:0] m_mem [256];

  // outputs sampled by the last step
  logic          s_cor_gnt, s_det_gnt, s_cfg_gnt, s_ram_en, s_ram_we, s_cor_rvalid, s_cfg_rvalid;
  logic [DW-1:0] s_ram_wdata, s_cor_rdata, s_cfg_rdata;
  logic [3:0]    s_starve;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check outputs at negedge against the model, advance the
  // model, then return 1 time unit after the next posedge for new stimulus.
  task automatic step();
    logic          e_cor, e_det, e_cfg, e_en, e_we, e_crv, e_frv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_crd, e_frd;
    int            e_st;
    @(negedge clk);
    if (rst) begin
      {e_cor, e_det, e_cfg, e_en, e_we, e_crv, e_frv} = '0;
      e_addr = '0; e_wd = '0; e_crd = '0; e_frd = '0; e_st = 0;
    end else begin
      e_cor  = cor_req;
      e_cfg  = !cor_req && cfg_req && (m_starve == LIM || !det_req);
      e_det  = !cor_req && det_req && !e_cfg;
      e_en   = e_cor || e_det || e_cfg;
      e_we   = e_det || (e_cfg && cfg_we);
      e_addr = e_cor ? cor_addr : e_det ? det_addr : e_cfg ? cfg_addr : '0;
      e_wd   = e_det ? det_wdata : (e_cfg && cfg_we) ? cfg_wdata : '0;
      e_crv  = (m_pend == 1);
      e_frv  = (m_pend == 2);
      e_crd  = e_crv ? m_pend_data : m_last_cor;
      e_frd  = e_frv ? m_pend_data : m_last_cfg;
      e_st   = m_starve;
    end
    chk("cor_gnt", DW'(cor_gnt), DW'(e_cor));
    chk("det_gnt", DW'(det_gnt), DW'(e_det));
    chk("cfg_gnt", DW'(cfg_gnt), DW'(e_cfg));
    chk("ram_en", DW'(ram_en), DW'(e_en));
    chk("ram_we", DW'(ram_we), DW'(e_we));
    chk("ram_addr", DW'(ram_addr), DW'(e_addr));
    chk("ram_wdata", ram_wdata, e_wd);
    chk("cor_rvalid", DW'(cor_rvalid), DW'(e_crv));
    chk("cfg_rvalid", DW'(cfg_rvalid), DW'(e_frv));
    chk("cor_rdata", cor_rdata, e_crd);
    chk("cfg_rdata", cfg_rdata, e_frd);
    chk("starve_cnt", DW'(cfg_starve_cnt), DW'(e_st));
    $display("cyc t=%0t rst=%0b req=%0b%0b%0b gnt=%0b%0b%0b en=%0b we=%0b a=%0h rv=%0b%0b cnt=%0d",
             $time, rst, cor_req, det_req, cfg_req, cor_gnt, det_gnt, cfg_gnt,
             ram_en, ram_we, ram_addr, cor_rvalid, cfg_rvalid, cfg_starve_cnt);
    s_cor_gnt = cor_gnt; s_det_gnt = det_gnt; s_cfg_gnt = cfg_gnt;
    s_ram_en = ram_en; s_ram_we = ram_we; s_ram_wdata = ram_wdata;
    s_cor_rvalid = cor_rvalid; s_cfg_rvalid = cfg_rvalid;
    s_cor_rdata = cor_rdata; s_cfg_rdata = cfg_rdata; s_starve = cfg_starve_cnt;
    if (rst) begin
      m_starve = 0; m_pend = 0; m_last_cor = '0; m_last_cfg = '0;
    end else begin
      m_last_cor = e_crd;
      m_last_cfg = e_frd;
      m_pend = e_cor ? 1 : (e_cfg && !cfg_we) ? 2 : 0;
      if (m_pend != 0) m_pend_data = m_mem[e_addr];
      if (e_we) m_mem[e_addr] = e_wd;
      m_starve = (cfg_req && !e_cfg) ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_env[i] = mem_init(i);
      m_mem[i]   = mem_init(i);
    end
    rst = 1'b1;
    {cor_req, det_req, cfg_req, cfg_we} = '0;
    cor_addr = '0; det_addr = '0; cfg_addr = '0; det_wdata = '0; cfg_wdata = '0;
    @(posedge clk); #1;
    step();
    cor_req = 1'b1;                         // request during reset must not be granted
    step();
    chk("rst_no_gnt", DW'(s_cor_gnt), 0);
    cor_req = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    chk("idle_ram_en", DW'(s_ram_en), 0);

    // corrector read of RAM[5]
    cor_req = 1'b1; cor_addr = 8'h05;
    step();
    chk("cor_rd_gnt", DW'(s_cor_gnt), 1);
    chk("cor_rd_we", DW'(s_ram_we), 0);
    cor_req = 1'b0;
    step();
    chk("cor_rd_rvalid", DW'(s_cor_rvalid), 1);
    chk("cor_rd_data", s_cor_rdata, 32'h0003_2040);
    chk("cor_rd_cfgrv", DW'(s_cfg_rvalid), 0);

    // three-way conflict
    cor_req = 1'b1; cor_addr = 8'h07;
    det_req = 1'b1; det_addr = 8'h08; det_wdata = 32'h1111_2222;
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h09; cfg_wdata = 32'h0000_3333;
    step();
    chk("tri_cor", DW'(s_cor_gnt), 1);
    cor_req = 1'b0;
    step();
    chk("tri_det", DW'(s_det_gnt), 1);
    chk("tri_det_we", DW'(s_ram_we), 1);
    chk("tri_det_wd", s_ram_wdata, 32'h1111_2222);
    det_req = 1'b0;
    step();
    chk("tri_cfg", DW'(s_cfg_gnt), 1);
    cfg_req = 1'b0; cfg_we = 1'b0;
    step();

    // starvation guard
    det_req = 1'b1; det_addr = 8'h14; det_wdata = 32'h0000_5555;
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h15;
    for (int k = 0; k <= LIM; k++) begin
      step();
      chk("starve_cnt_seq", DW'(s_starve), DW'(k));
      chk("starve_cfg_gnt", DW'(s_cfg_gnt), (k == LIM) ? 32'd1 : 32'd0);
    end
    cfg_req = 1'b0;
    step();
    chk("starve_clear", DW'(s_starve), 0);
    det_req = 1'b0;
    step();

    // cfg write then read back
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h10; cfg_wdata = 32'h0000_ABCD;
    step();
    cfg_we = 1'b0;
    step();
    cfg_req = 1'b0;
    step();
    chk("cfg_rb_rvalid", DW'(s_cfg_rvalid), 1);
    chk("cfg_rb_data", s_cfg_rdata, 32'h0000_ABCD);

    // reset right after a granted read
    cor_req = 1'b1; cor_addr = 8'h03;
    step();
    cor_req = 1'b0; rst = 1'b1;
    step();
    chk("rst_rd_rvalid", DW'(s_cor_rvalid), 0);
    chk("rst_rd_rdata", s_cor_rdata, 0);
    rst = 1'b0;
    step();
    chk("rst_rd_after", DW'(s_cor_rvalid), 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (s_cor_gnt || !cor_req) begin
        cor_req  = ($urandom_range(0, 99) < 30);
        cor_addr = AW'($urandom_range(0, 31));
      end
      if (s_det_gnt || !det_req) begin
        det_req   = ($urandom_range(0, 99) < 60);
        det_addr  = AW'($urandom_range(0, 31));
        det_wdata = $urandom;
      end
      if (s_cfg_gnt || !cfg_req) begin
        cfg_req   = ($urandom_range(0, 99) < 40);
        cfg_we    = $urandom_range(0, 1) == 1;
        cfg_addr  = AW'($urandom_range(0, 31));
        cfg_wdata = $urandom;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dpc_bp_table_arbiter.md
Name: dpc_bp_table_arbiter

Overview:
- Shares one single-port bad-pixel coordinate RAM between three requesters: the corrector read stream (cor), the auto-detector result writer (det), and the AXI-Lite manual-table/readback path (cfg).
- Grants one access per cycle under fixed priority, with a starvation guard for cfg.
- Tags each read and returns its data, with a valid strobe, to the requester that issued it.
- Sits between the DPC detector/corrector cores, the AXI-Lite slave and the bad-pixel table RAM.

Parameters:
ADDR_WIDTH, 8, table address width (table depth = 2**ADDR_WIDTH entries)
DATA_WIDTH, 32, table word width ({y[9:0], x[9:0]} packed in the low 20 bits)
STARVE_LIMIT, 4, consecutive lost arbitrations after which cfg beats det (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cor_req  in  1  corrector read request, held until granted
cor_addr  in  ADDR_WIDTH  corrector read address
cor_gnt  out  1  corrector grant (combinational)
cor_rvalid  out  1  corrector read data valid
cor_rdata  out  DATA_WIDTH  corrector read data
det_req  in  1  detector write request, held until granted
det_addr  in  ADDR_WIDTH  detector write address
det_wdata  in  DATA_WIDTH  detector write data
det_gnt  out  1  detector grant (combinational)
cfg_req  in  1  AXI-side request, held until granted
cfg_we  in  1  1 = write, 0 = read
cfg_addr  in  ADDR_WIDTH  AXI-side address
cfg_wdata  in  DATA_WIDTH  AXI-side write data
cfg_gnt  out  1  AXI-side grant (combinational)
cfg_rvalid  out  1  AXI-side read data valid
cfg_rdata  out  DATA_WIDTH  AXI-side read data
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_en with ram_we=0
cfg_starve_cnt  out  4  current cfg wait count (debug)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Grants and RAM signals are combinational from the current requests and registered state.
  - At most one gnt is high per cycle.
  - A request completes in the cycle its gnt is high.
- Priority per cycle:
  - cor_req always wins.
  - Otherwise, if cfg_req and cfg_starve_cnt == STARVE_LIMIT, cfg wins.
  - Otherwise det wins over cfg.
- RAM drive by winner:
  - ram_en = 1 when any request is granted.
  - ram_we = 1 for det, or for cfg with cfg_we = 1; ram_we = 0 for cor reads.
  - ram_addr / ram_wdata come from the winner.
  - ram_wdata = 0 on reads.
  - With no grant, ram_en = 0, ram_we = 0, addr/data = 0.
- Starvation counter (4-bit register):
  - Increments (saturating at STARVE_LIMIT) each cycle cfg_req = 1 and cfg_gnt = 0.
  - Clears on cfg_gnt, or when cfg_req = 0.
  - The override does not apply against cor; cfg may wait indefinitely under back-to-back cor.
- Read return:
  - A registered 2-bit tag records the owner of a granted read (NONE/COR/CFG).
  - The cycle after the grant, exactly one of cor_rvalid / cfg_rvalid pulses for 1 cycle.
  - The matching rdata then equals ram_rdata.
  - rdata outputs hold their last value otherwise.
  - Latency is grant + 1 cycle; back-to-back reads give back-to-back rvalid pulses.
- Writes produce no rvalid.
- Same-cycle conflicts:
  - Only the winner accesses RAM; losers keep req asserted.
  - A read granted the cycle after a write to the same address returns the new data (RAM read-after-write ordering; no bypass here).
- Reset:
  - All gnt = 0 while rst = 1.
  - ram_en = 0, ram_we = 0, rvalid = 0, rdata = 0, tag = NONE, cfg_starve_cnt = 0.
  - A read granted the cycle rst rises produces no rvalid.
- Address range: full 2**ADDR_WIDTH space is legal; no wrap or translation (cfg_addr is already table-relative).

Test Plan:
- Reset, then idle: all req = 0 -> ram_en = 0, all gnt = 0, rvalid never asserted.
- cor_req with cor_addr = 0x05, RAM[5] = 0x0003_2040 -> cor_gnt same cycle, ram_we = 0; cor_rvalid next cycle with cor_rdata = 0x0003_2040, cfg_rvalid = 0.
- cor, det and cfg (write) all request in the same cycle -> cor granted; next cycle det granted (ram_we = 1, det_wdata driven); then cfg granted.
- det_req held continuously, cfg read held, STARVE_LIMIT = 4 -> cfg_starve_cnt counts 1,2,3,4; cfg_gnt on the 5th cycle; counter returns to 0.
- cfg write addr 0x10 data 0xABCD, then cfg read addr 0x10 -> cfg_rvalid one cycle after the read grant, cfg_rdata = 0xABCD.
- Read granted, rst asserted the next cycle -> no rvalid, tag = NONE, and all outputs at reset values.
